// File: rtl/core_types_pkg.sv
// Shared types and defaults for the branch predictor.
// FSM states, default table geometry, counter init helper.
package core_types_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  localparam int BP_ENTRIES = 16;
  localparam int BP_CNT_W   = 2;

  // weakly not-taken: just below the taken threshold
  function automatic int bp_init_val(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Decode lookup, execute update and statistics bundle.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if;

  logic [31:0] lookup_pc;
  logic        lookup_valid;
  logic        predict_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        ready;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output lookup_pc,
    output lookup_valid,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_mispredict,
    input  predict_taken,
    input  ready,
    input  branch_count,
    input  mispredict_count
  );

  modport slave (
    input  lookup_pc,
    input  lookup_valid,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_mispredict,
    output predict_taken,
    output ready,
    output branch_count,
    output mispredict_count
  );

endinterface

// File: rtl/bp_table.sv
// Counter array with saturating read-modify-write update.
// Async read port; init write has priority over update.
module bp_table
  import core_types_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int CNT_W   = BP_CNT_W,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             init_we_i,
  input  logic [IDX_W-1:0] init_idx_i,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o
);

  localparam logic [CNT_W-1:0] INIT_VAL =
    CNT_W'(bp_init_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_d;

  // saturating next value for the entry being trained
  always_comb begin
    upd_cur = cnt_q[upd_idx_i];
    upd_d   = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != CNT_MAX)
        upd_d = upd_cur + CNT_W'(1);
    end else begin
      if (upd_cur != '0)
        upd_d = upd_cur - CNT_W'(1);
    end
  end

  // one write per cycle: init sweep or update
  always_ff @(posedge clk_i) begin
    if (init_we_i)
      cnt_q[init_idx_i] <= INIT_VAL;
    else if (upd_en_i)
      cnt_q[upd_idx_i] <= upd_d;
  end

  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Conditional branch predictor: INIT sweep FSM, stats.
// Macro BRANCH_PRED_GSHARE_EN xors global history into idx.
module branch_predictor
  import core_types_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int CNT_W   = BP_CNT_W
) (
  input logic               Clock,
  input logic               Reset,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_state_t        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [31:0]      branch_count_q, branch_count_d;
  logic [31:0]      mispredict_count_q;
  logic [31:0]      mispredict_count_d;
  logic             ready_w;
  logic             run_upd;
  logic             init_we;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic             unused_pc;

  assign ready_w = (state_q == RUN);
  assign run_upd = ready_w & bp.upd_valid & ~Reset;

`ifdef BRANCH_PRED_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // shift each resolved outcome into the history
  always_comb begin
    ghr_d = ghr_q;
    if (run_upd)
      ghr_d = {ghr_q[IDX_W-2:0], bp.upd_taken};
  end

  // history register
  always_ff @(posedge Clock) begin
    if (Reset)
      ghr_q <= '0;
    else
      ghr_q <= ghr_d;
  end

  assign lk_idx = bp.lookup_pc[IDX_W+1:2] ^ ghr_q;
  assign up_idx = bp.upd_pc[IDX_W+1:2] ^ ghr_q;
`else
  assign lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign up_idx = bp.upd_pc[IDX_W+1:2];
`endif

  assign unused_pc = ^{bp.lookup_pc[31:IDX_W+2],
                       bp.lookup_pc[1:0],
                       bp.upd_pc[31:IDX_W+2],
                       bp.upd_pc[1:0]};

  // sweep one entry per cycle, then run
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    init_we    = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we    = 1'b1;
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(ENTRIES - 1))
          state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // resolved-branch and misprediction counters
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (run_upd) begin
      branch_count_d = branch_count_q + 32'd1;
      if (bp.upd_mispredict)
        mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  // state, sweep pointer and statistics registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q            <= INIT;
      init_idx_q         <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      init_idx_q         <= init_idx_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  bp_table #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk_i       (Clock),
    .init_we_i   (init_we),
    .init_idx_i  (init_idx_q),
    .upd_en_i    (run_upd),
    .upd_idx_i   (up_idx),
    .upd_taken_i (bp.upd_taken),
    .rd_idx_i    (lk_idx),
    .rd_cnt_o    (rd_cnt)
  );

  assign bp.predict_taken = rd_cnt[CNT_W-1]
                          & bp.lookup_valid
                          & ready_w
                          & ~Reset;
  assign bp.ready            = ready_w;
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of history-table entries (power of two, 4..1024).
REQ-002 SHALL have parameter CNT_W, default 2, saturating-counter width in bits (1..4).
REQ-003 SHALL have port Clock input 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset input 1, synchronous, active-high reset.
REQ-005 SHALL have port lookup_pc input 32, PC of the branch being decoded.
REQ-006 SHALL have port lookup_valid input 1, a conditional branch is in decode this cycle.
REQ-007 SHALL have port predict_taken output 1, the prediction for lookup_pc.
REQ-008 SHALL have port upd_valid input 1, a conditional branch resolved in execute this cycle.
REQ-009 SHALL have port upd_pc input 32, PC of the resolved branch.
REQ-010 SHALL have port upd_taken input 1, actual outcome of the resolved branch.
REQ-011 SHALL have port upd_mispredict input 1, resolved outcome differs from the prediction issued.
REQ-012 SHALL have port ready output 1, table initialised and predictions valid.
REQ-013 SHALL have port branch_count output 32, resolved conditional branches since reset.
REQ-014 SHALL have port mispredict_count output 32, mispredictions since reset.

Function
REQ-015 SHALL index the table with IDX = lookup_pc/upd_pc bits [IDX_W+1:2], where IDX_W = clog2(ENTRIES).
REQ-016 SHALL drive predict_taken combinationally as the MSB of the indexed counter AND lookup_valid AND ready.
REQ-017 SHALL, on upd_valid in RUN, increment the indexed counter if upd_taken, else decrement, saturating at 2^CNT_W-1 and 0.
REQ-018 SHALL make an update visible to lookups from the next cycle; a same-cycle lookup of the updated index returns the old value.
REQ-019 SHALL implement FSM states INIT and RUN: INIT writes counter value 2^(CNT_W-1)-1 (weakly not-taken) to one entry per cycle, in index order 0..ENTRIES-1.
REQ-020 SHALL transition INIT->RUN on the cycle after entry ENTRIES-1 is written, so ready rises exactly ENTRIES cycles after Reset deasserts.
REQ-021 SHALL ignore upd_valid during INIT: no table, history or statistics change.
REQ-022 SHALL, in RUN, increment branch_count on each upd_valid and increment mispredict_count on each upd_valid AND upd_mispredict.
REQ-023 SHALL wrap both statistics counters from 0xFFFFFFFF to 0.
REQ-024 SHALL ignore upd_mispredict when upd_valid is low.

Reset
REQ-025 SHALL, on Reset, set state INIT, init index 0, ready 0, branch_count 0, mispredict_count 0, global history 0.
REQ-026 SHALL restart the full INIT sweep when Reset asserts mid-sweep or mid-RUN; predict_taken SHALL read 0 until ready.
REQ-027 SHALL keep predict_taken combinationally 0 while Reset is high.

Configuration
REQ-028 SHALL support macro BRANCH_PRED_GSHARE_EN.
REQ-029 SHALL, with BRANCH_PRED_GSHARE_EN defined, keep an IDX_W-bit global history register that shifts in upd_taken at the LSB on each upd_valid in RUN, and XOR it into both lookup and update indices.
REQ-030 SHALL, without BRANCH_PRED_GSHARE_EN, omit the history register and use the pure PC index of REQ-015.

Structure
REQ-031 SHALL declare bp_state_t (INIT, RUN) and the default ENTRIES/CNT_W constants in core_types_pkg.
REQ-032 SHALL place the counter array and its saturating read-modify-write logic in sub-module bp_table; branch_predictor holds the FSM, indexing, history and statistics.

Verification
REQ-033 SHALL verify init: deassert Reset; ready stays 0 for 16 cycles and is 1 on cycle 16; lookup of any PC then returns 0.
REQ-034 SHALL verify training: upd_valid, upd_pc=0x40, upd_taken=1 twice (CNT_W=2) -> lookup 0x40 returns 1 from the cycle after the first update, and the counter saturates at 3 after a third update.
REQ-035 SHALL verify aliasing: ENTRIES=16; training 0x40 taken makes lookup 0x80 predict 1 (gshare off), and two not-taken updates to 0x80 make 0x40 predict 0.
REQ-036 SHALL verify statistics: 5 updates, 2 with upd_mispredict -> branch_count 5, mispredict_count 2; forcing 0xFFFFFFFF then one update -> 0.
REQ-037 SHALL verify reset mid-operation: Reset asserted after training -> ready 0, counts 0, and after 16 cycles 0x40 predicts 0; an update issued during INIT leaves all counters unchanged.
REQ-038 SHALL verify gshare (macro on): after history 0b0001, lookup 0x40 reads entry 0x0 XOR 0x1 = 0x1, and an update to 0x40 modifies entry 1.
